// File: rtl/lab7_soc_oci_pkg.sv
// Shared definitions for the OCI debug-capture-trace (DCT) capture block.
package lab7_soc_oci_pkg;

    typedef enum logic [1:0] {
        ST_CAPTURE = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    localparam int DEF_DATA_W = 30;
    localparam int DEF_CNT_W  = 4;
    localparam int DEF_DEPTH  = 16;
    localparam int DEF_DROP_W = 8;

endpackage

// File: rtl/lab7_soc_oci_dct_fifo.sv
// Show-ahead FIFO: storage, wrapping pointers and occupancy level.
// Latency: a push at edge N is visible at the head after N.
// Backpressure: none internally; the caller qualifies push (not full or popping) and pop (not empty).
module lab7_soc_oci_dct_fifo
    import lab7_soc_oci_pkg::*;
#(
    parameter int W     = DEF_DATA_W + DEF_CNT_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [W-1:0]               i_dat,
    output logic [W-1:0]               o_dat,
    output logic [$clog2(DEPTH):0]     o_level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;

    // Storage is not reset; only pointers and level define validity.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_dat;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_dat   = r_mem[r_rd_ptr];
    assign o_level = r_level;

endmodule

// File: rtl/lab7_soc_nios2_qsys_0_oci_dct_capture.sv
// Buffers non-empty DCT frames, drains them on valid/ready, flags drops and end of test.
// Latency: 1 cycle push-to-read; show-ahead head entry.
// Backpressure: none upstream; frames arriving while full without a pop are dropped and counted.
module lab7_soc_nios2_qsys_0_oci_dct_capture
    import lab7_soc_oci_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int DROP_W = DEF_DROP_W
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [DATA_W-1:0]        dct_buffer,
    input  logic [CNT_W-1:0]         dct_count,
    input  logic                     dct_valid,
    input  logic                     test_ending,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [DATA_W-1:0]        rd_data,
    output logic [CNT_W-1:0]         rd_count,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [DROP_W-1:0]        drop_cnt,
    output logic                     test_has_ended
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    state_e                   r_state;
    state_e                   w_state_nxt;
    logic                     r_overflow;
    logic [DROP_W-1:0]        r_drop_cnt;
    logic [LVL_W-1:0]         w_level;
    logic [CNT_W+DATA_W-1:0]  w_head;
    logic                     w_rd_valid;
    logic                     w_pop;
    logic                     w_push_req;
    logic                     w_full;
    logic                     w_push;
    logic                     w_drop;

    // A full FIFO still accepts a frame when the head leaves in the same cycle.
    assign w_rd_valid = (w_level != '0) && (r_state != ST_DONE);
    assign w_pop      = w_rd_valid && rd_ready;
    assign w_push_req = (r_state == ST_CAPTURE) && dct_valid && (dct_count != '0);
    assign w_full     = (w_level == LVL_W'(DEPTH));
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;

    lab7_soc_oci_dct_fifo #(
        .W     (CNT_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_dat   ({dct_count, dct_buffer}),
        .o_dat   (w_head),
        .o_level (w_level)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != '1) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_CAPTURE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // DRAIN looks at the registered level, so DONE lands one cycle after it hits zero.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CAPTURE: if (test_ending)      w_state_nxt = ST_DRAIN;
            ST_DRAIN:   if (w_level == '0)    w_state_nxt = ST_DONE;
            ST_DONE:                          w_state_nxt = ST_DONE;
            default:                          w_state_nxt = ST_CAPTURE;
        endcase
    end

    always_comb begin
        test_has_ended = 1'b0;
        if (r_state == ST_DONE) begin
            test_has_ended = 1'b1;
        end
    end

    assign rd_valid = w_rd_valid;
    assign rd_data  = w_head[DATA_W-1:0];
    assign rd_count = w_head[CNT_W+DATA_W-1:DATA_W];
    assign level    = w_level;
    assign overflow = r_overflow;
    assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_lab7_soc_nios2_qsys_0_oci_dct_capture.sv
// Directed bench for the DCT capture block: filtering, overflow, end-of-test drain, async reset.
module tb_lab7_soc_nios2_qsys_0_oci_dct_capture;

    logic        clk;
    logic        reset_n;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        dct_valid;
    logic        test_ending;
    logic        rd_ready;
    logic        rd_valid;
    logic [29:0] rd_data;
    logic [3:0]  rd_count;
    logic [4:0]  level;
    logic        overflow;
    logic [7:0]  drop_cnt;
    logic        test_has_ended;

    int n_vec = 0;
    int n_err = 0;

    lab7_soc_nios2_qsys_0_oci_dct_capture #(
        .DATA_W (30),
        .CNT_W  (4),
        .DEPTH  (16),
        .DROP_W (8)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .dct_valid      (dct_valid),
        .test_ending    (test_ending),
        .rd_ready       (rd_ready),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data),
        .rd_count       (rd_count),
        .level          (level),
        .overflow       (overflow),
        .drop_cnt       (drop_cnt),
        .test_has_ended (test_has_ended)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rd_valid"}, 64'(rd_valid), 64'd0);
        chk({tag, "_level"},    64'(level), 64'd0);
        chk({tag, "_overflow"}, 64'(overflow), 64'd0);
        chk({tag, "_drop_cnt"}, 64'(drop_cnt), 64'd0);
        chk({tag, "_ended"},    64'(test_has_ended), 64'd0);
    endtask

    function automatic logic [3:0] cnt_of(input int i);
        return 4'((i % 15) + 1);
    endfunction

    initial begin
        reset_n     = 1'b0;
        dct_buffer  = '0;
        dct_count   = '0;
        dct_valid   = 1'b0;
        test_ending = 1'b0;
        rd_ready    = 1'b0;
        #12;
        chk_reset_vals("reset");
        step();
        reset_n = 1'b1;
        step();

        // First push: visible one cycle later
        dct_buffer = 30'h0000_0ABC; dct_count = 4'd3; dct_valid = 1'b1;
        step();
        dct_valid = 1'b0;
        chk("first_vld",   64'(rd_valid), 64'd1);
        chk("first_data",  64'(rd_data), 64'h0ABC);
        chk("first_count", 64'(rd_count), 64'd3);
        chk("first_level", 64'(level), 64'd1);
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        chk("first_pop_level", 64'(level), 64'd0);
        chk("first_pop_vld",   64'(rd_valid), 64'd0);

        // Zero-count frames are discarded, not dropped
        for (int i = 0; i < 5; i++) begin
            dct_buffer = 30'(i + 100); dct_count = 4'd0; dct_valid = 1'b1;
            step();
        end
        dct_valid = 1'b0;
        chk("zero_level",    64'(level), 64'd0);
        chk("zero_overflow", 64'(overflow), 64'd0);
        chk("zero_drop",     64'(drop_cnt), 64'd0);

        // Overflow: 20 frames into 16 entries
        for (int i = 1; i <= 20; i++) begin
            dct_buffer = 30'(i); dct_count = cnt_of(i); dct_valid = 1'b1;
            step();
        end
        dct_valid = 1'b0;
        chk("ovf_level",    64'(level), 64'd16);
        chk("ovf_overflow", 64'(overflow), 64'd1);
        chk("ovf_drop",     64'(drop_cnt), 64'd4);

        // Full with simultaneous push and pop: head 1 leaves, 0x3FF enters
        chk("full_head", 64'(rd_data), 64'd1);
        dct_buffer = 30'h3FF; dct_count = 4'hF; dct_valid = 1'b1; rd_ready = 1'b1;
        step();
        dct_valid = 1'b0; rd_ready = 1'b0;
        chk("full_pp_level", 64'(level), 64'd16);
        chk("full_pp_drop",  64'(drop_cnt), 64'd4);

        rd_ready = 1'b1;
        for (int i = 2; i <= 16; i++) begin
            chk($sformatf("drain_data_%0d", i),  64'(rd_data), 64'(i));
            chk($sformatf("drain_count_%0d", i), 64'(rd_count), 64'(cnt_of(i)));
            step();
        end
        chk("last_vld",   64'(rd_valid), 64'd1);
        chk("last_data",  64'(rd_data), 64'h3FF);
        chk("last_count", 64'(rd_count), 64'hF);
        step();
        rd_ready = 1'b0;
        chk("drained_level", 64'(level), 64'd0);
        chk("drained_vld",   64'(rd_valid), 64'd0);

        // End of test: 3 queued, 4th with test_ending, pushes in DRAIN ignored
        for (int i = 0; i < 3; i++) begin
            dct_buffer = 30'(32'h100 + i); dct_count = 4'd2; dct_valid = 1'b1;
            step();
        end
        dct_buffer = 30'h103; dct_count = 4'd2; dct_valid = 1'b1; test_ending = 1'b1;
        step();
        test_ending = 1'b0;
        chk("eot_level4", 64'(level), 64'd4);
        for (int i = 0; i < 3; i++) begin
            dct_buffer = 30'(32'h200 + i); dct_count = 4'd5; dct_valid = 1'b1;
            step();
        end
        dct_valid = 1'b0;
        chk("drain_push_level", 64'(level), 64'd4);
        chk("drain_push_drop",  64'(drop_cnt), 64'd4);
        chk("drain_ended0",     64'(test_has_ended), 64'd0);

        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("eot_vld_%0d", i),  64'(rd_valid), 64'd1);
            chk($sformatf("eot_data_%0d", i), 64'(rd_data), 64'(32'h100 + i));
            step();
        end
        chk("eot_level0",      64'(level), 64'd0);
        chk("eot_ended_early", 64'(test_has_ended), 64'd0);
        step();
        chk("eot_ended",  64'(test_has_ended), 64'd1);
        chk("eot_vld_lo", 64'(rd_valid), 64'd0);

        // DONE is sticky: a new test_ending and pushes change nothing
        dct_buffer = 30'h555; dct_count = 4'd1; dct_valid = 1'b1; test_ending = 1'b1;
        step();
        test_ending = 1'b0;
        step();
        step();
        dct_valid = 1'b0; rd_ready = 1'b0;
        chk("done_sticky", 64'(test_has_ended), 64'd1);
        chk("done_level",  64'(level), 64'd0);
        chk("done_vld",    64'(rd_valid), 64'd0);

        // Fresh run: saturate drop counter, partly drain, enter DRAIN with level 5
        reset_n = 1'b0;
        #2;
        chk("reset2_ended", 64'(test_has_ended), 64'd0);
        step();
        reset_n = 1'b1;
        step();
        for (int i = 1; i <= 276; i++) begin
            dct_buffer = 30'(i); dct_count = 4'd1; dct_valid = 1'b1;
            step();
        end
        dct_valid = 1'b0;
        chk("sat_level", 64'(level), 64'd16);
        chk("sat_drop",  64'(drop_cnt), 64'd255);
        rd_ready = 1'b1;
        for (int i = 0; i < 11; i++) step();
        rd_ready = 1'b0;
        chk("mid_level", 64'(level), 64'd5);
        chk("mid_head",  64'(rd_data), 64'd12);
        test_ending = 1'b1;
        step();
        test_ending = 1'b0;
        dct_buffer = 30'h777; dct_count = 4'd3; dct_valid = 1'b1;
        step();
        step();
        dct_valid = 1'b0;
        chk("mid_drain_level", 64'(level), 64'd5);

        // Asynchronous reset away from the clock edge
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_vals("async_reset");
        step();
        reset_n = 1'b1;
        step();
        // Back in CAPTURE: a push is accepted again
        dct_buffer = 30'h0DEF; dct_count = 4'd7; dct_valid = 1'b1;
        step();
        dct_valid = 1'b0;
        chk("post_reset_level", 64'(level), 64'd1);
        chk("post_reset_data",  64'(rd_data), 64'h0DEF);
        chk("post_reset_ended", 64'(test_has_ended), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
